onecounter_rr_scheduler: RTL and testbench
==========================================

Name: onecounter_rr_scheduler

Overview:
- Shares one bit-1-counter engine (the FSM+datapath pair, one 32-bit operand, 32-bit count result) among NUM_REQ requesters.
- Round-robin arbitration. Latches the winner's operand, sequences the engine's start/done handshake, and returns the result with a one-cycle ack tagged with the requester index.
- Sits between client blocks and the engine. It is the engine's only driver of start and input data.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester index; must equal clog2(NUM_REQ)
START_HOLD, 4, i_clk cycles o_engStart is held high; must be at least 2 engine sysClk periods (engine sysClk = i_clk/2, so minimum 4)
TIMEOUT_CYCLES, 1024, watchdog limit in WAIT (used only with the optional feature)

Ports:
i_clk  in  1  system clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_req  in  NUM_REQ  per-requester request level
i_data  in  NUM_REQ*32  per-requester operand; slice k = bits [32k+31:32k]
o_gnt  out  NUM_REQ  one-hot grant, held from grant until ack
o_ack  out  1  one-cycle pulse: result valid
o_ackId  out  ID_W  index of the requester being acked
o_result  out  32  count result, valid while o_ack=1
o_err  out  1  timeout flag, valid with o_ack (tied 0 without the optional feature)
o_busy  out  1  high in every state except IDLE
o_engStart  out  1  engine start
o_engData  out  32  engine operand, stable from ISSUE until RESP exit
i_engDone  in  1  engine done level (high while the engine is in its output state)
i_engResult  in  32  engine result, valid while i_engDone=1

Behaviour:
- Reset (async, any state, including mid-service): state=IDLE, rrPtr=0. All outputs 0. Any in-flight service is abandoned and produces no ack.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any i_req is set, pick the first set bit scanning upward from rrPtr, wrapping modulo NUM_REQ.
  - Register the one-hot grant in o_gnt, latch that slice into o_engData, set holdCnt=0, go to ISSUE.
  - Grant appears the cycle after i_req is sampled high.
- ISSUE: o_engStart=1. holdCnt increments. When holdCnt reaches START_HOLD-1, go to WAIT and drop o_engStart.
- WAIT:
  - Keep doneQ, a registered copy of i_engDone.
  - On the rising edge (i_engDone=1 and doneQ=0): o_result<=i_engResult, o_ackId<=granted index, o_ack<=1 for exactly 1 cycle. Go to RESP.
- RESP:
  - Hold o_gnt and o_engData until i_engDone=0, so the engine is back in its idle state before the next start.
  - Then clear o_gnt, set rrPtr=(granted index+1) mod NUM_REQ, go to IDLE.
- Latency, request to ack: 1 (grant) + START_HOLD + engine latency + 1.
- Requester rules:
  - i_req may drop after grant. The service still completes and the ack is still issued.
  - i_data changes after grant are ignored.
  - A requester that holds i_req after its ack is re-arbitrated normally. rrPtr ensures other pending requesters are served first.
- Simultaneous requests: exactly one grant. The others wait in IDLE arbitration.
- Engine data 0x00000000 is passed through unmodified; the engine returns 0.
- o_ack never coincides with o_engStart.

Optional Feature:
- Macro: ONECOUNTER_SCHED_TIMEOUT_EN.
- With the macro:
  - A 32-bit counter clears on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES with no done edge, pulse o_ack with o_err=1 and o_result=0x00000000, advance rrPtr, and go to IDLE directly (skip RESP).
  - A late i_engDone edge arriving in IDLE is ignored.
- Without the macro: no counter, o_err constant 0, WAIT has no timeout.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3.
  - DATA_W=32.
  - Default START_HOLD and TIMEOUT_CYCLES.
- Sub-module rr_arbiter: combinational priority scan from rrPtr. Inputs i_req and rrPtr; outputs one-hot grant, index, and a valid flag. It is reusable by other shared-engine schedulers.

Test Plan:
- Single request: i_req=4'b0001, i_data[31:0]=0xFFFFFFFF -> o_gnt=0001, o_engStart high exactly 4 cycles, o_ack pulse with o_ackId=0, o_result=32, o_err=0.
- Round-robin order: i_req=4'b1011 held; slices 0x1, 0x3, 0x7 on requesters 0, 1, 3 -> acks in order ids 0,1,3,0 with results 1,2,3,1; requester 2 never granted.
- Fairness after wrap: serve id 3 with rrPtr=3, then i_req=4'b1001 -> next grant is id 0, not id 3.
- Request dropped and data changed: requester 2 drops i_req and changes i_data to 0x0 one cycle after grant, original data 0x80000001 -> ack id 2, result 2.
- Reset in WAIT: assert i_rst mid-service -> all outputs 0 immediately, no ack; after release, i_req=4'b0100 -> grant 0100.
- With ONECOUNTER_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, engine done tied 0 -> ack with o_err=1, o_result=0 after 16 WAIT cycles; scheduler returns to IDLE and serves the next requester.

Source files
------------

// File: rtl/onecounter_rr_scheduler_pkg.sv
// rtl/onecounter_rr_scheduler_pkg.sv - shared types and constants for the bit-1-counter engine scheduler
package onecounter_rr_scheduler_pkg;

  localparam int DATA_W             = 32;
  localparam int DEF_START_HOLD     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/onecounter_rr_scheduler_rr_arbiter.sv
// rtl/onecounter_rr_scheduler_rr_arbiter.sv - combinational round-robin pick starting at a rotating pointer
module onecounter_rr_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_valid
);

  logic [ID_W-1:0] cand;

  // Scan from the farthest slot back to the pointer so the slot nearest the pointer wins last.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(i_ptr) + k) % NUM_REQ);
      if (i_req[cand]) begin
        o_valid = 1'b1;
        o_idx   = cand;
      end
    end
    if (o_valid) begin
      o_gnt[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/onecounter_rr_scheduler.sv
// rtl/onecounter_rr_scheduler.sv - shares one bit-1-counter engine among requesters; optional watchdog via ONECOUNTER_SCHED_TIMEOUT_EN
module onecounter_rr_scheduler
  import onecounter_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int START_HOLD     = DEF_START_HOLD,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*DATA_W-1:0] i_data,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic                      o_ack,
  output logic [ID_W-1:0]           o_ackId,
  output logic [DATA_W-1:0]         o_result,
  output logic                      o_err,
  output logic                      o_busy,
  output logic                      o_engStart,
  output logic [DATA_W-1:0]         o_engData,
  input  logic                      i_engDone,
  input  logic [DATA_W-1:0]         i_engResult
);

  localparam int HOLD_W = $clog2(START_HOLD);

  if (ID_W != $clog2(NUM_REQ) || START_HOLD < 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("onecounter_rr_scheduler: inconsistent parameters");
  end

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]     gnt_idx_q, gnt_idx_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     ack_id_q, ack_id_d;
  logic [DATA_W-1:0]   eng_data_q, eng_data_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                done_q, done_d;
  logic                ack_q, ack_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [ID_W-1:0]     arb_idx;
  logic                arb_valid;
  logic [ID_W-1:0]     next_ptr;

`ifdef ONECOUNTER_SCHED_TIMEOUT_EN
  logic [31:0]         to_cnt_q, to_cnt_d;
  logic                err_q, err_d;
`endif

  onecounter_rr_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_req   (i_req),
    .i_ptr   (rr_ptr_q),
    .o_gnt   (arb_gnt),
    .o_idx   (arb_idx),
    .o_valid (arb_valid)
  );

  // Pointer moves just past the requester that was served so the others get the next turn.
  assign next_ptr = (gnt_idx_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;

  // Next-state and datapath: arbitrate, hold start, catch the done edge, wait for the engine to go idle.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    rr_ptr_d   = rr_ptr_q;
    ack_id_d   = ack_id_q;
    eng_data_d = eng_data_q;
    result_d   = result_q;
    hold_cnt_d = hold_cnt_q;
    done_d     = i_engDone;
    ack_d      = 1'b0;
`ifdef ONECOUNTER_SCHED_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d      = arb_gnt;
          gnt_idx_d  = arb_idx;
          eng_data_d = i_data[DATA_W*int'(arb_idx) +: DATA_W];
          hold_cnt_d = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (hold_cnt_q == HOLD_W'(START_HOLD - 1)) begin
          state_d = WAIT;
`ifdef ONECOUNTER_SCHED_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (i_engDone && !done_q) begin
          result_d = i_engResult;
          ack_id_d = gnt_idx_q;
          ack_d    = 1'b1;
          state_d  = RESP;
        end
`ifdef ONECOUNTER_SCHED_TIMEOUT_EN
        else if (to_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          result_d = '0;
          ack_id_d = gnt_idx_q;
          ack_d    = 1'b1;
          err_d    = 1'b1;
          gnt_d    = '0;
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 32'd1;
        end
`endif
      end
      RESP: begin
        if (!i_engDone) begin
          gnt_d    = '0;
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any service in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      rr_ptr_q   <= '0;
      ack_id_q   <= '0;
      eng_data_q <= '0;
      result_q   <= '0;
      hold_cnt_q <= '0;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
`ifdef ONECOUNTER_SCHED_TIMEOUT_EN
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      ack_id_q   <= ack_id_d;
      eng_data_q <= eng_data_d;
      result_q   <= result_d;
      hold_cnt_q <= hold_cnt_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
`ifdef ONECOUNTER_SCHED_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign o_gnt      = gnt_q;
  assign o_ack      = ack_q;
  assign o_ackId    = ack_id_q;
  assign o_result   = result_q;
  assign o_busy     = (state_q != IDLE);
  assign o_engStart = (state_q == ISSUE);
  assign o_engData  = eng_data_q;
`ifdef ONECOUNTER_SCHED_TIMEOUT_EN
  assign o_err      = err_q;
`else
  assign o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_onecounter_rr_scheduler.sv
// tb/tb_onecounter_rr_scheduler.sv - scoreboard bench for onecounter_rr_scheduler (timeout case with ONECOUNTER_SCHED_TIMEOUT_EN)
module tb_onecounter_rr_scheduler;

  localparam int NUM_REQ    = 4;
  localparam int ID_W       = 2;
  localparam int START_HOLD = 4;
  localparam int ENG_LAT    = 5;
`ifdef ONECOUNTER_SCHED_TIMEOUT_EN
  localparam int TO_CYC     = 16;
`else
  localparam int TO_CYC     = 1024;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ*32-1:0]  data;
  logic [NUM_REQ-1:0]     o_gnt;
  logic                   o_ack;
  logic [ID_W-1:0]        o_ackId;
  logic [31:0]            o_result;
  logic                   o_err;
  logic                   o_busy;
  logic                   o_engStart;
  logic [31:0]            o_engData;
  logic                   eng_done;
  logic [31:0]            eng_result;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     res;
    logic            err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   acks_seen = 0;
  int   start_run = 0;
  logic track_rr = 1'b0;
  logic gnt2_seen = 1'b0;
  logic eng_en = 1'b1;
  int   eng_st, eng_cnt;

  always #5 clk = ~clk;

  onecounter_rr_scheduler #(
    .NUM_REQ        (NUM_REQ),
    .ID_W           (ID_W),
    .START_HOLD     (START_HOLD),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_data      (data),
    .o_gnt       (o_gnt),
    .o_ack       (o_ack),
    .o_ackId     (o_ackId),
    .o_result    (o_result),
    .o_err       (o_err),
    .o_busy      (o_busy),
    .o_engStart  (o_engStart),
    .o_engData   (o_engData),
    .i_engDone   (eng_done),
    .i_engResult (eng_result)
  );

  // Engine model: counts ones after start falls, holds done for three cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_st     <= 0;
      eng_cnt    <= 0;
      eng_done   <= 1'b0;
      eng_result <= '0;
    end else begin
      case (eng_st)
        0: if (o_engStart) eng_st <= 1;
        1: if (!o_engStart) begin
             eng_cnt <= 0;
             eng_st  <= eng_en ? 2 : 0;
           end
        2: if (eng_cnt == ENG_LAT - 1) begin
             eng_done   <= 1'b1;
             eng_result <= 32'($countones(o_engData));
             eng_cnt    <= 0;
             eng_st     <= 3;
           end else eng_cnt <= eng_cnt + 1;
        3: if (eng_cnt == 2) begin
             eng_done <= 1'b0;
             eng_st   <= 0;
           end else eng_cnt <= eng_cnt + 1;
        default: eng_st <= 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [ID_W-1:0] id, input logic [31:0] res, input logic err);
    exp_t e;
    e.id  = id;
    e.res = res;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_acks(input int n, input string name);
    int tgt;
    tgt = acks_seen + n;
    for (int c = 0; c < 400 && acks_seen < tgt; c++) tick();
    chk(name, acks_seen, tgt);
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 100 && o_busy; c++) tick();
    chk(name, o_busy, 0);
  endtask

  // Monitor: pops the scoreboard on every ack and checks start pulse width.
  always @(negedge clk) begin
    if (rst) begin
      start_run = 0;
    end else begin
      if (o_engStart) start_run++;
      else if (start_run != 0) begin
        chk("start_len", start_run, START_HOLD);
        start_run = 0;
      end
      if (track_rr && o_gnt[2]) gnt2_seen = 1'b1;
      if (o_ack) begin
        acks_seen++;
        chk("ack_no_start", o_engStart, 0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got id=%0d result=%h, want no ack", o_ackId, o_result);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_id", o_ackId, mon_e.id);
          chk("ack_result", o_result, mon_e.res);
          chk("ack_err", o_err, mon_e.err);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = '0;
    data = '0;
    repeat (3) tick();
    chk("rst_gnt", o_gnt, 0);
    chk("rst_ack", o_ack, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_start", o_engStart, 0);
    chk("rst_engdata", o_engData, 0);
    chk("rst_result", o_result, 0);
    rst = 1'b0;
    tick();

    // single request, all ones
    data[31:0] = 32'hFFFF_FFFF;
    req = 4'b0001;
    push(0, 32, 0);
    tick();
    chk("t1_gnt", o_gnt, 4'b0001);
    chk("t1_engdata", o_engData, 32'hFFFF_FFFF);
    req = 4'b0000;
    wait_acks(1, "t1_ack_wait");
    wait_idle("t1_idle");

    // round robin from pointer 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    data[31:0]   = 32'h1;
    data[63:32]  = 32'h3;
    data[95:64]  = 32'hFFFF;
    data[127:96] = 32'h7;
    push(0, 1, 0);
    push(1, 2, 0);
    push(3, 3, 0);
    push(0, 1, 0);
    track_rr = 1'b1;
    req = 4'b1011;
    wait_acks(4, "t2_ack_wait");
    req = 4'b0000;
    wait_idle("t2_idle");
    track_rr = 1'b0;
    chk("t2_req2_never", gnt2_seen, 0);

    // serve 3, then 0 must win over 3 after wrap; zero operand passes through
    data[127:96] = 32'hF;
    req = 4'b1000;
    push(3, 4, 0);
    tick();
    chk("t3_gnt3", o_gnt, 4'b1000);
    req = 4'b0000;
    wait_acks(1, "t3_ack3_wait");
    wait_idle("t3_idle");
    data[31:0] = 32'h0;
    req = 4'b1001;
    push(0, 0, 0);
    push(3, 4, 0);
    tick();
    chk("t3_wrap_gnt", o_gnt, 4'b0001);
    chk("t3_zero_data", o_engData, 0);
    wait_acks(2, "t3_ack_wait");
    req = 4'b0000;
    wait_idle("t3_idle2");

    // request dropped and operand changed after grant
    data[95:64] = 32'h8000_0001;
    req = 4'b0100;
    push(2, 2, 0);
    tick();
    chk("t4_gnt", o_gnt, 4'b0100);
    req = 4'b0000;
    data[95:64] = 32'h0;
    tick();
    chk("t4_data_held", o_engData, 32'h8000_0001);
    chk("t4_gnt_held", o_gnt, 4'b0100);
    wait_acks(1, "t4_ack_wait");
    wait_idle("t4_idle");

    // reset while waiting on the engine
    data[63:32] = 32'hFF;
    req = 4'b0010;
    tick();
    chk("t5_gnt", o_gnt, 4'b0010);
    req = 4'b0000;
    repeat (5) tick();
    chk("t5_pre_busy", o_busy, 1);
    chk("t5_pre_start", o_engStart, 0);
    rst = 1'b1;
    #1;
    chk("t5_rst_gnt", o_gnt, 0);
    chk("t5_rst_busy", o_busy, 0);
    chk("t5_rst_start", o_engStart, 0);
    chk("t5_rst_engdata", o_engData, 0);
    chk("t5_rst_ack", o_ack, 0);
    chk("t5_rst_result", o_result, 0);
    chk("t5_rst_err", o_err, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    data[95:64] = 32'h3;
    req = 4'b0100;
    push(2, 2, 0);
    tick();
    chk("t5_post_gnt", o_gnt, 4'b0100);
    req = 4'b0000;
    wait_acks(1, "t5_ack_wait");
    wait_idle("t5_idle");

`ifdef ONECOUNTER_SCHED_TIMEOUT_EN
    // engine never answers: timeout ack, then the next requester is served
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    eng_en = 1'b0;
    data[31:0]  = 32'h1;
    data[63:32] = 32'h3;
    req = 4'b0011;
    push(0, 0, 1);
    push(1, 2, 0);
    tick();
    chk("t6_gnt", o_gnt, 4'b0001);
    req = 4'b0010;
    wait_acks(1, "t6_timeout_wait");
    chk("t6_idle_after_to", o_busy, 0);
    chk("t6_gnt_cleared", o_gnt, 0);
    eng_en = 1'b1;
    wait_acks(1, "t6_next_wait");
    req = 4'b0000;
    wait_idle("t6_idle");
`endif

    repeat (4) tick();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
